i2c_reg_sequencer: RTL and testbench
====================================

// Module: i2c_reg_sequencer
// PURPOSE
// - Sequences one I2C register transaction (8-bit reg addr, 8-bit data) into byte-level commands for the I2C byte engine.
// - Sits between a register-access client and the engine; owns START/RESTART/STOP ordering, ACK checking and error reporting.
// - Handles one transaction at a time; the client is back-pressured while busy.
// PARAMETERS
// - MAX_RETRY  3   address-NACK retries; used only with I2C_RETRY_EN; 0 means no retry
// - RETRY_GAP  64  idle cycles between the STOP of a failed attempt and the retry START; >=1
// PORTS
// - clk          in   1  system clock
// - rst_n        in   1  synchronous reset, active low
// - req_valid    in   1  transaction request
// - req_ready    out  1  high only in IDLE
// - req_rnw      in   1  1=read, 0=write
// - req_dev_addr in   7  7-bit device address
// - req_reg_addr in   8  register address
// - req_wdata    in   8  write data, ignored on read
// - done_valid   out  1  1-cycle pulse: transaction finished
// - done_rdata   out  8  read data, valid with done_valid; 0 on write or error
// - done_err     out  1  NACK seen, valid with done_valid
// - busy         out  1  high from request acceptance until done_valid inclusive
// - cmd_valid    out  1  command to engine
// - cmd_ready    in   1  engine accepts command
// - cmd_op       out  3  0 START, 1 RESTART, 2 WRITE, 3 READ_ACK, 4 READ_NACK, 5 STOP
// - cmd_wdata    out  8  byte for WRITE, else 0
// - rsp_valid    in   1  one pulse per accepted command, in order
// - rsp_rdata    in   8  byte from READ_*
// - rsp_nack     in   1  slave NACK on WRITE
// BEHAVIOUR
// - Reset: IDLE; req_ready=1; cmd_valid, done_valid, done_err, busy=0; cmd_op, cmd_wdata, done_rdata=0; retry count=0.
// - Accept on req_valid&&req_ready; request fields are latched then. Next cycle: START state, cmd_valid=1.
// - Write sequence: START, WRITE{dev,0}, WRITE reg, WRITE wdata, STOP.
// - Read sequence: START, WRITE{dev,0}, WRITE reg, RESTART, WRITE{dev,1}, READ_NACK, STOP.
// - Each bus state has two phases: ISSUE holds cmd_valid and a stable cmd_op/cmd_wdata until cmd_ready; WAIT then waits for rsp_valid.
// - cmd_valid drops the cycle after the handshake. Never more than one command is outstanding.
// - rsp_valid arriving in the same cycle as the handshake is not legal; the engine responds at least 1 cycle later.
// - rsp_nack=1 on any WRITE: set err, go directly to STOP. Remaining bytes are skipped.
// - rsp_nack is ignored for non-WRITE ops.
// - READ_NACK response: capture rsp_rdata into done_rdata.
// - STOP response: go to DONE. DONE drives done_valid=1 for one cycle, then IDLE (req_ready=1 on the following cycle).
// - Min idle-to-idle: 2 cycles per command + 2; zero-latency engine gives 12 cycles for a write, 16 for a read.
// - rsp_valid outside WAIT is ignored.
// - req_valid while busy is ignored; it is not queued.
// - rst_n low mid-transaction: IDLE on the next edge, cmd_valid=0, no done pulse, no STOP issued. The engine is reset by the same reset.
// CONFIGURATION
// - I2C_RETRY_EN defined: a NACK on a device-address WRITE (either phase) issues STOP, then waits RETRY_GAP cycles, then restarts the full sequence from START.
//   Retries continue up to MAX_RETRY times. Retry count clears on new request acceptance.
//   done_err=1 only when retries are exhausted; a NACK on the reg or data byte is never retried.
// - I2C_RETRY_EN undefined: no retry logic or counter; any NACK -> STOP -> done_err=1.
// TESTING
// - Write dev 0x50 reg 0x10 data 0xA5, always-ACK engine -> ops 0,2(0xA0),2(0x10),2(0xA5),5; done_err=0; done_rdata=0.
// - Read dev 0x68 reg 0x75, engine returns 0x71 -> ops 0,2(0xD0),2(0x75),1,2(0xD1),4,5; done_rdata=0x71; done_err=0.
// - NACK on the reg byte of a write -> next op is STOP (no data byte); done_err=1; one done_valid pulse.
// - cmd_ready held low for 20 cycles on each op -> cmd_op/cmd_wdata stable while stalled; sequence unchanged.
// - I2C_RETRY_EN, MAX_RETRY=2, address NACK on every attempt -> 3 STARTs, each STOP followed by >=RETRY_GAP idle cycles; done_err=1.
//   Same setup with an ACK on the 2nd attempt -> done_err=0.
// - rst_n low during WAIT of the reg byte -> next cycle cmd_valid=0, req_ready=1, no done_valid; a new write then completes normally.

Source files
------------

// File: rtl/i2c_reg_sequencer.sv
// rtl/i2c_reg_sequencer.sv - sequences one 8-bit-register I2C transaction into byte-engine commands
// Optional address-NACK retry is built when I2C_RETRY_EN is defined.
module i2c_reg_sequencer #(
  parameter int MAX_RETRY = 3,
  parameter int RETRY_GAP = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rnw,
  input  logic [6:0] req_dev_addr,
  input  logic [7:0] req_reg_addr,
  input  logic [7:0] req_wdata,
  output logic       done_valid,
  output logic [7:0] done_rdata,
  output logic       done_err,
  output logic       busy,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [2:0] cmd_op,
  output logic [7:0] cmd_wdata,
  input  logic       rsp_valid,
  input  logic [7:0] rsp_rdata,
  input  logic       rsp_nack
);

  localparam logic [2:0] OP_START     = 3'd0;
  localparam logic [2:0] OP_RESTART   = 3'd1;
  localparam logic [2:0] OP_WRITE     = 3'd2;
  localparam logic [2:0] OP_READ_NACK = 3'd4;
  localparam logic [2:0] OP_STOP      = 3'd5;

  if (RETRY_GAP < 1 || MAX_RETRY < 0) begin : g_cfg_check
    $error("i2c_reg_sequencer: RETRY_GAP must be >= 1 and MAX_RETRY >= 0");
  end

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_DONE} state_e;
  typedef enum logic [2:0] {
    ST_START, ST_DEV_W, ST_REG, ST_DATA, ST_RESTART, ST_DEV_R, ST_READ, ST_STOP
  } step_e;

  state_e     state_q, state_d;
  step_e      step_q, step_d, step_after;
  logic       rnw_q, rnw_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       err_q, err_d;
  logic       step_is_write;

`ifdef I2C_RETRY_EN
  localparam int RC_W  = $clog2(MAX_RETRY + 2);
  localparam int GAP_W = $clog2(RETRY_GAP + 1);
  logic [RC_W-1:0]  retry_cnt_q, retry_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             retry_q, retry_d;
  logic             step_is_dev;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= ST_START;
      rnw_q   <= 1'b0;
      dev_q   <= 7'd0;
      reg_q   <= 8'd0;
      wdata_q <= 8'd0;
      rdata_q <= 8'd0;
      err_q   <= 1'b0;
`ifdef I2C_RETRY_EN
      retry_cnt_q <= '0;
      gap_cnt_q   <= '0;
      retry_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      rnw_q   <= rnw_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef I2C_RETRY_EN
      retry_cnt_q <= retry_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      retry_q     <= retry_d;
`endif
    end
  end

  // Reads branch off after the register byte into RESTART + device-read + READ_NACK.
  always_comb begin
    step_after = ST_STOP;
    case (step_q)
      ST_START:   step_after = ST_DEV_W;
      ST_DEV_W:   step_after = ST_REG;
      ST_REG:     step_after = rnw_q ? ST_RESTART : ST_DATA;
      ST_RESTART: step_after = ST_DEV_R;
      ST_DEV_R:   step_after = ST_READ;
      default:    step_after = ST_STOP;
    endcase
    step_is_write = (step_q == ST_DEV_W) || (step_q == ST_REG) ||
                    (step_q == ST_DATA)  || (step_q == ST_DEV_R);
`ifdef I2C_RETRY_EN
    step_is_dev = (step_q == ST_DEV_W) || (step_q == ST_DEV_R);
`endif
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    rnw_d   = rnw_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef I2C_RETRY_EN
    retry_cnt_d = retry_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    retry_d     = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_ISSUE;
          step_d  = ST_START;
          rnw_d   = req_rnw;
          dev_d   = req_dev_addr;
          reg_d   = req_reg_addr;
          wdata_d = req_wdata;
          rdata_d = 8'd0;
          err_d   = 1'b0;
`ifdef I2C_RETRY_EN
          retry_cnt_d = '0;
          retry_d     = 1'b0;
`endif
        end
      end
      S_ISSUE: begin
        if (cmd_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rsp_valid) begin
          if (step_q == ST_STOP) begin
`ifdef I2C_RETRY_EN
            if (retry_q) begin
              state_d   = S_GAP;
              gap_cnt_d = GAP_W'(RETRY_GAP - 1);
            end else begin
              state_d = S_DONE;
            end
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_ISSUE;
            if (step_is_write && rsp_nack) begin
              step_d = ST_STOP;
`ifdef I2C_RETRY_EN
              if (step_is_dev && (retry_cnt_q < RC_W'(MAX_RETRY))) begin
                retry_d     = 1'b1;
                retry_cnt_d = retry_cnt_q + 1'b1;
              end else begin
                err_d = 1'b1;
              end
`else
              err_d = 1'b1;
`endif
            end else begin
              step_d = step_after;
              if (step_q == ST_READ) rdata_d = rsp_rdata;
            end
          end
        end
      end
`ifdef I2C_RETRY_EN
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = S_ISSUE;
          step_d  = ST_START;
          retry_d = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    busy       = (state_q != S_IDLE);
    cmd_valid  = (state_q == S_ISSUE);
    done_valid = (state_q == S_DONE);
    done_err   = done_valid && err_q;
    done_rdata = (done_valid && !err_q) ? rdata_q : 8'd0;
    cmd_op     = OP_START;
    cmd_wdata  = 8'd0;
    if (cmd_valid) begin
      case (step_q)
        ST_START:   cmd_op = OP_START;
        ST_DEV_W:   begin cmd_op = OP_WRITE; cmd_wdata = {dev_q, 1'b0}; end
        ST_REG:     begin cmd_op = OP_WRITE; cmd_wdata = reg_q;         end
        ST_DATA:    begin cmd_op = OP_WRITE; cmd_wdata = wdata_q;       end
        ST_RESTART: cmd_op = OP_RESTART;
        ST_DEV_R:   begin cmd_op = OP_WRITE; cmd_wdata = {dev_q, 1'b1}; end
        ST_READ:    cmd_op = OP_READ_NACK;
        default:    cmd_op = OP_STOP;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb/tb_i2c_reg_sequencer.sv - scoreboard bench for i2c_reg_sequencer with a modelled byte engine
module tb_i2c_reg_sequencer;

  localparam int TB_MAX_RETRY = 2;
  localparam int TB_GAP       = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rnw = 1'b0;
  logic [6:0] req_dev_addr = 7'd0;
  logic [7:0] req_reg_addr = 8'd0;
  logic [7:0] req_wdata = 8'd0;
  logic       done_valid;
  logic [7:0] done_rdata;
  logic       done_err;
  logic       busy;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;

  always #5 clk = ~clk;

  i2c_reg_sequencer #(.MAX_RETRY(TB_MAX_RETRY), .RETRY_GAP(TB_GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
    .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
    .done_valid(done_valid), .done_rdata(done_rdata), .done_err(done_err), .busy(busy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [10:0] exp_ops[$];
  logic [8:0]  exp_done[$];

  int         eng_stall = 0, eng_lat = 0, nack_idx = -1, nack_attempts = 0, txn_id = 0;
  bit         nack_nonwrite = 1'b0, spurious = 1'b0;
  logic [7:0] rd_byte = 8'd0;

  int          cmd_idx = 0, attempt = 0, last_txn = -1, stall_cnt = 0, rsp_wait = 0;
  int          stop_cyc = 0, done_cnt = 0;
  bit          hs_pending = 1'b0, rsp_pending = 1'b0;
  logic        pend_nack = 1'b0;
  logic [7:0]  pend_rdata = 8'd0;
  logic [10:0] held_cmd = '0, eng_exp = '0;
  logic [8:0]  mon_exp = '0;

  // Engine model: accepts one command, answers eng_lat cycles after the handshake cycle.
  initial begin
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_rdata = 8'd0;
    forever begin
      @(posedge clk); #1;
      rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_rdata = 8'd0;
      if (!rst_n) begin
        hs_pending = 1'b0; rsp_pending = 1'b0; stall_cnt = 0; cmd_ready = 1'b0;
      end else begin
        if (hs_pending) begin
          hs_pending = 1'b0; rsp_pending = 1'b1; rsp_wait = eng_lat;
        end
        if (rsp_pending) begin
          if (rsp_wait == 0) begin
            rsp_valid = 1'b1; rsp_nack = pend_nack; rsp_rdata = pend_rdata; rsp_pending = 1'b0;
          end else begin
            rsp_wait--;
          end
        end
        cmd_ready = 1'b0;
        if (cmd_valid && !hs_pending && !rsp_pending) begin
          if (stall_cnt == 0) begin
            held_cmd = {cmd_op, cmd_wdata};
          end else begin
            total++;
            if ({cmd_op, cmd_wdata} !== held_cmd) begin
              bad++;
              $display("FAIL stall_stable: got op/data %h want %h", {cmd_op, cmd_wdata}, held_cmd);
            end
          end
          if (stall_cnt < eng_stall) begin
            stall_cnt++;
            if (spurious) begin rsp_valid = 1'b1; rsp_nack = 1'b1; rsp_rdata = 8'hEE; end
          end else begin
            cmd_ready = 1'b1; stall_cnt = 0; hs_pending = 1'b1;
            if (cmd_op == 3'd0) begin
              if (txn_id != last_txn) begin last_txn = txn_id; attempt = 1; end
              else attempt++;
`ifdef I2C_RETRY_EN
              if (attempt > 1) begin
                total++;
                if (cyc - stop_cyc - 1 < TB_GAP) begin
                  bad++;
                  $display("FAIL retry_gap: got %0d idle cycles want >= %0d", cyc - stop_cyc - 1, TB_GAP);
                end
              end
`endif
              cmd_idx = 0;
            end
            if (cmd_op == 3'd5) stop_cyc = cyc;
            pend_nack  = (cmd_op == 3'd2 && cmd_idx == nack_idx && attempt <= nack_attempts) ||
                         (cmd_op != 3'd2 && nack_nonwrite);
            pend_rdata = (cmd_op == 3'd4) ? rd_byte : 8'h3C;
            cmd_idx++;
            total++;
            if (exp_ops.size() == 0) begin
              bad++;
              $display("FAIL cmd_unexpected: got op/data %h want none", {cmd_op, cmd_wdata});
            end else begin
              eng_exp = exp_ops.pop_front();
              if ({cmd_op, cmd_wdata} !== eng_exp) begin
                bad++;
                $display("FAIL cmd_seq: got op/data %h want %h", {cmd_op, cmd_wdata}, eng_exp);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (done_valid === 1'b1) begin
        done_cnt++;
        total++;
        if (exp_done.size() == 0) begin
          bad++;
          $display("FAIL done_unexpected: got err/rdata %h want none", {done_err, done_rdata});
        end else begin
          mon_exp = exp_done.pop_front();
          if ({done_err, done_rdata} !== mon_exp) begin
            bad++;
            $display("FAIL done_result: got err/rdata %h want %h", {done_err, done_rdata}, mon_exp);
          end
        end
      end
    end
  end

  task automatic push_attempt(input bit rnw, input logic [6:0] dev, input logic [7:0] ra,
                              input logic [7:0] wd, input int nk);
    logic [10:0] seq[$];
    seq = {};
    seq.push_back({3'd0, 8'h00});
    seq.push_back({3'd2, dev, 1'b0});
    seq.push_back({3'd2, ra});
    if (rnw) begin
      seq.push_back({3'd1, 8'h00});
      seq.push_back({3'd2, dev, 1'b1});
      seq.push_back({3'd4, 8'h00});
    end else begin
      seq.push_back({3'd2, wd});
    end
    for (int i = 0; i < seq.size(); i++) begin
      exp_ops.push_back(seq[i]);
      if (i == nk) break;
    end
    exp_ops.push_back({3'd5, 8'h00});
  endtask

  task automatic start_req(input bit rnw, input logic [6:0] dev, input logic [7:0] ra,
                           input logic [7:0] wd);
    txn_id++;
    req_valid = 1'b1; req_rnw = rnw; req_dev_addr = dev; req_reg_addr = ra; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (req_ready !== 1'b1 && n < 3000) begin @(posedge clk); #1; n++; end
    if (req_ready !== 1'b1) n = -1;
  endtask

  task automatic eng_cfg(input int stall, input int lat, input int nk, input int natt);
    eng_stall = stall; eng_lat = lat; nack_idx = nk; nack_attempts = natt;
    nack_nonwrite = 1'b0; spurious = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total += 8;
    if (req_ready !== 1'b1)  begin bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    if (cmd_valid !== 1'b0)  begin bad++; $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); end
    if (done_valid !== 1'b0) begin bad++; $display("FAIL reset_done_valid: got %b want 0", done_valid); end
    if (done_err !== 1'b0)   begin bad++; $display("FAIL reset_done_err: got %b want 0", done_err); end
    if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (cmd_op !== 3'd0)     begin bad++; $display("FAIL reset_cmd_op: got %0d want 0", cmd_op); end
    if (cmd_wdata !== 8'd0)  begin bad++; $display("FAIL reset_cmd_wdata: got %h want 00", cmd_wdata); end
    if (done_rdata !== 8'd0) begin bad++; $display("FAIL reset_done_rdata: got %h want 00", done_rdata); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    int n, d0;
    eng_cfg(0, 0, -1, 0);
    d0 = done_cnt;
    push_attempt(1'b0, 7'h50, 8'h10, 8'hA5, -1);
    exp_done.push_back({1'b0, 8'h00});
    start_req(1'b0, 7'h50, 8'h10, 8'hA5);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL write_busy: got %b want 1", busy); end
    wait_idle(n);
    total += 2;
    if (n + 1 != 12) begin bad++; $display("FAIL write_idle_to_idle: got %0d want 12", n + 1); end
    if (done_cnt != d0 + 1) begin bad++; $display("FAIL write_done_count: got %0d want %0d", done_cnt - d0, 1); end
  endtask

  task automatic test_read();
    int n;
    eng_cfg(0, 0, -1, 0);
    nack_nonwrite = 1'b1;
    rd_byte = 8'h71;
    push_attempt(1'b1, 7'h68, 8'h75, 8'h00, -1);
    exp_done.push_back({1'b0, 8'h71});
    start_req(1'b1, 7'h68, 8'h75, 8'h99);
    wait_idle(n);
    total++;
    if (n + 1 != 16) begin bad++; $display("FAIL read_idle_to_idle: got %0d want 16", n + 1); end
  endtask

  task automatic test_nack();
    int n, d0;
    d0 = done_cnt;
    eng_cfg(0, 0, 2, 100);
    push_attempt(1'b0, 7'h50, 8'h10, 8'hA5, 2);
    exp_done.push_back({1'b1, 8'h00});
    start_req(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_idle(n);
    eng_cfg(0, 1, 3, 100);
    push_attempt(1'b0, 7'h33, 8'h44, 8'h55, 3);
    exp_done.push_back({1'b1, 8'h00});
    start_req(1'b0, 7'h33, 8'h44, 8'h55);
    wait_idle(n);
`ifndef I2C_RETRY_EN
    eng_cfg(0, 0, 4, 100);
    rd_byte = 8'h6B;
    push_attempt(1'b1, 7'h21, 8'h07, 8'h00, 4);
    exp_done.push_back({1'b1, 8'h00});
    start_req(1'b1, 7'h21, 8'h07, 8'h00);
    wait_idle(n);
    d0 = d0 - 1;
`endif
    total++;
    if (n < 0) begin bad++; $display("FAIL nack_timeout: got timeout want idle"); end
`ifndef I2C_RETRY_EN
    d0 = d0 + 1;
    total++;
    if (done_cnt != d0 + 3) begin bad++; $display("FAIL nack_done_count: got %0d want 3", done_cnt - d0); end
`else
    total++;
    if (done_cnt != d0 + 2) begin bad++; $display("FAIL nack_done_count: got %0d want 2", done_cnt - d0); end
`endif
  endtask

  task automatic test_stall();
    int n;
    eng_cfg(20, 2, -1, 0);
    spurious = 1'b1;
    rd_byte = 8'h5A;
    push_attempt(1'b0, 7'h50, 8'h10, 8'hA5, -1);
    exp_done.push_back({1'b0, 8'h00});
    start_req(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_idle(n);
    push_attempt(1'b1, 7'h68, 8'h75, 8'h00, -1);
    exp_done.push_back({1'b0, 8'h5A});
    start_req(1'b1, 7'h68, 8'h75, 8'h00);
    wait_idle(n);
    total++;
    if (n < 0) begin bad++; $display("FAIL stall_timeout: got timeout want idle"); end
  endtask

  task automatic test_back_to_back();
    int n, d0;
    bit rnw;
    logic [6:0] dev;
    logic [7:0] ra, wd;
    d0 = done_cnt;
    for (int t = 0; t < 5; t++) begin
      eng_cfg(0, int'($urandom_range(0, 3)), -1, 0);
      rnw = 1'(($urandom_range(0, 1)));
      dev = 7'($urandom); ra = 8'($urandom); wd = 8'($urandom);
      rd_byte = 8'($urandom);
      push_attempt(rnw, dev, ra, wd, -1);
      exp_done.push_back({1'b0, rnw ? rd_byte : 8'h00});
      start_req(rnw, dev, ra, wd);
      if (t == 0) begin
        req_valid = 1'b1; req_rnw = ~rnw; req_dev_addr = ~dev; req_reg_addr = ~ra;
        repeat (5) @(posedge clk);
        #1;
        req_valid = 1'b0;
      end
      wait_idle(n);
    end
    total++;
    if (done_cnt != d0 + 5) begin bad++; $display("FAIL b2b_done_count: got %0d want 5", done_cnt - d0); end
  endtask

`ifdef I2C_RETRY_EN
  task automatic test_retry();
    int n;
    eng_cfg(0, 0, 1, 100);
    for (int a = 0; a <= TB_MAX_RETRY; a++) push_attempt(1'b0, 7'h2A, 8'h01, 8'h02, 1);
    exp_done.push_back({1'b1, 8'h00});
    start_req(1'b0, 7'h2A, 8'h01, 8'h02);
    wait_idle(n);
    total++;
    if (attempt != TB_MAX_RETRY + 1) begin bad++; $display("FAIL retry_starts: got %0d want %0d", attempt, TB_MAX_RETRY + 1); end
    eng_cfg(0, 0, 1, 1);
    push_attempt(1'b0, 7'h2A, 8'h03, 8'h04, 1);
    push_attempt(1'b0, 7'h2A, 8'h03, 8'h04, -1);
    exp_done.push_back({1'b0, 8'h00});
    start_req(1'b0, 7'h2A, 8'h03, 8'h04);
    wait_idle(n);
    total++;
    if (attempt != 2) begin bad++; $display("FAIL retry_recover_starts: got %0d want 2", attempt); end
    eng_cfg(0, 0, 4, 1);
    rd_byte = 8'hC3;
    push_attempt(1'b1, 7'h11, 8'h22, 8'h00, 4);
    push_attempt(1'b1, 7'h11, 8'h22, 8'h00, -1);
    exp_done.push_back({1'b0, 8'hC3});
    start_req(1'b1, 7'h11, 8'h22, 8'h00);
    wait_idle(n);
    total++;
    if (attempt != 2) begin bad++; $display("FAIL retry_read_starts: got %0d want 2", attempt); end
  endtask
`endif

  task automatic test_reset_mid();
    int n, d0;
    eng_cfg(0, 10, -1, 0);
    d0 = done_cnt;
    push_attempt(1'b0, 7'h50, 8'h10, 8'hA5, -1);
    exp_done.push_back({1'b0, 8'h00});
    start_req(1'b0, 7'h50, 8'h10, 8'hA5);
    n = 0;
    while (!(cmd_valid === 1'b1 && cmd_op === 3'd2 && cmd_wdata === 8'h10) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    while (cmd_valid === 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    total++;
    if (n >= 200) begin bad++; $display("FAIL mid_reach_reg_wait: got timeout want reg byte"); end
    rst_n = 1'b0;
    exp_ops.delete();
    exp_done.delete();
    @(posedge clk); #1;
    total += 3;
    if (cmd_valid !== 1'b0) begin bad++; $display("FAIL mid_cmd_valid: got %b want 0", cmd_valid); end
    if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_req_ready: got %b want 1", req_ready); end
    if (busy !== 1'b0)      begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    total++;
    if (done_cnt != d0) begin bad++; $display("FAIL mid_no_done: got %0d pulses want 0", done_cnt - d0); end
    eng_cfg(0, 0, -1, 0);
    push_attempt(1'b0, 7'h3C, 8'h81, 8'h7E, -1);
    exp_done.push_back({1'b0, 8'h00});
    start_req(1'b0, 7'h3C, 8'h81, 8'h7E);
    wait_idle(n);
    total += 2;
    if (n + 1 != 12) begin bad++; $display("FAIL mid_after_idle_to_idle: got %0d want 12", n + 1); end
    if (done_cnt != d0 + 1) begin bad++; $display("FAIL mid_after_done: got %0d want 1", done_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_stall();
    test_back_to_back();
`ifdef I2C_RETRY_EN
    test_retry();
`endif
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    total += 2;
    if (exp_ops.size() != 0)  begin bad++; $display("FAIL ops_leftover: got %0d want 0", exp_ops.size()); end
    if (exp_done.size() != 0) begin bad++; $display("FAIL done_leftover: got %0d want 0", exp_done.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
